// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and the control unit that drives it.
package mult_div_pkg;
    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV
    } md_state_t;
endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: a radix-2 Booth step for MULT, a restoring trial subtract for DIV.
module md_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                    op,
    input  logic signed [WIDTH:0]   hi_in,
    input  logic        [WIDTH-1:0] lo_in,
    input  logic                    q_in,
    input  logic signed [WIDTH:0]   operand,
    output logic signed [WIDTH:0]   hi_out,
    output logic        [WIDTH-1:0] lo_out,
    output logic                    q_out
);
    logic signed [WIDTH+1:0] sum;
    logic        [WIDTH+1:0] shifted;

    always_comb begin
        sum     = '0;
        shifted = '0;
        hi_out  = hi_in;
        lo_out  = lo_in;
        q_out   = q_in;
        if (op == OP_MULT) begin
            // The sum is kept one bit wider so subtracting -2^WIDTH-1 cannot overflow before the shift.
            case ({lo_in[0], q_in})
                2'b01:   sum = {hi_in[WIDTH], hi_in} + {operand[WIDTH], operand};
                2'b10:   sum = {hi_in[WIDTH], hi_in} - {operand[WIDTH], operand};
                default: sum = {hi_in[WIDTH], hi_in};
            endcase
            hi_out = sum[WIDTH+1:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
            q_out  = lo_in[0];
        end else begin
            shifted = {1'b0, hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
            sum     = shifted - {1'b0, operand};
            hi_out  = sum[WIDTH+1] ? shifted[WIDTH:0] : sum[WIDTH:0];
            lo_out  = {lo_in[WIDTH-2:0], ~sum[WIDTH+1]};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit with architectural HI/LO; fixed 32-iteration latency, DIV0 flagged without iterating.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_write,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(MD_ITER);

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    md_state_t               state;
    logic        [CNT_W-1:0] count;
    logic                    op_r;
    logic                    a_neg;
    logic                    b_neg;
    logic signed [WIDTH:0]   operand_r;
    logic signed [WIDTH:0]   acc_hi;
    logic        [WIDTH-1:0] acc_lo;
    logic                    acc_q;
    logic        [WIDTH-1:0] staging_hi;
    logic        [WIDTH-1:0] staging_lo;

    logic signed [WIDTH:0]   nxt_hi;
    logic        [WIDTH-1:0] nxt_lo;
    logic                    nxt_q;
    logic        [WIDTH-1:0] res_hi;
    logic        [WIDTH-1:0] res_lo;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_r),
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .q_in    (acc_q),
        .operand (operand_r),
        .hi_out  (nxt_hi),
        .lo_out  (nxt_lo),
        .q_out   (nxt_q)
    );

    // Division runs on magnitudes; the quotient and remainder signs are restored on the final step.
    always_comb begin
        res_hi = nxt_hi[WIDTH-1:0];
        res_lo = nxt_lo;
        if (op_r == OP_DIV) begin
            res_lo = cond_neg(a_neg ^ b_neg, nxt_lo);
            res_hi = cond_neg(a_neg, nxt_hi[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state      <= IDLE;
            count      <= '0;
            op_r       <= OP_MULT;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            operand_r  <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            acc_q      <= 1'b0;
            staging_hi <= '0;
            staging_lo <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div0       <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        a_neg  <= a[WIDTH-1];
                        b_neg  <= b[WIDTH-1];
                        count  <= CNT_W'(MD_ITER - 1);
                        acc_hi <= '0;
                        acc_q  <= 1'b0;
                        if (op == OP_MULT) begin
                            acc_lo    <= b;
                            operand_r <= {a[WIDTH-1], a};
                            state     <= MULT;
                            busy      <= 1'b1;
                        end else if (b == '0) begin
                            done <= 1'b1;
                            div0 <= 1'b1;
                        end else begin
                            acc_lo    <= mag(a);
                            operand_r <= {1'b0, mag(b)};
                            state     <= DIV;
                            busy      <= 1'b1;
                        end
                    end
                end
                MULT, DIV: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    acc_q  <= nxt_q;
                    if (count == '0) begin
                        staging_hi <= res_hi;
                        staging_lo <= res_lo;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Staging already holds the fresh result in the done cycle, so a same-cycle write commits it.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_write) begin
            hi <= staging_hi;
            lo <= staging_lo;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, DIV0, start-while-busy, abort and back-to-back.
module tb_mult_div_unit;
    logic        clk;
    logic        reset_in;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_write;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .hilo_write (hilo_write),
        .busy       (busy),
        .done       (done),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge with the unit idle; returns in cycle 1.
    task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 100) begin
            tick();
            c++;
        end
    endtask

    task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        start_op(o, x, y);
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        wait_done(1, c);
        check({tag, "_latency"}, 64'(c), 64'd33);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        hilo_write = 1'b1;
        tick();
        hilo_write = 1'b0;
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int c;
        int done_seen;
        n_cmp      = 0;
        n_err      = 0;
        reset_in   = 1'b0;
        start      = 1'b0;
        op         = 1'b0;
        a          = '0;
        b          = '0;
        hilo_write = 1'b0;
        repeat (3) tick();
        reset_in = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        do_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        // 0x451 = 0x22 * 0x20 + 0x11
        do_op("div_preload", 1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022);

        start_op(1'b1, 32'd5, 32'd0);
        check("div0_done", 64'(done), 64'd1);
        check("div0_flag", 64'(div0), 64'd1);
        check("div0_busy", 64'(busy), 64'd0);
        hilo_write = 1'b1;
        tick();
        hilo_write = 1'b0;
        check("div0_done_clear", 64'(done), 64'd0);
        check("div0_flag_clear", 64'(div0), 64'd0);
        check("div0_busy2", 64'(busy), 64'd0);
        check("div0_hi", 64'(hi), 64'h11);
        check("div0_lo", 64'(lo), 64'h22);

        start_op(1'b0, 32'd6, 32'd9);
        repeat (4) tick();
        op    = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(6, c);
        check("restart_latency", 64'(c), 64'd33);
        hilo_write = 1'b1;
        tick();
        hilo_write = 1'b0;
        check("restart_hi", 64'(hi), 64'd0);
        check("restart_lo", 64'(lo), 64'd54);

        start_op(1'b1, 32'd100, 32'd7);
        repeat (9) tick();
        reset_in = 1'b0;
        tick();
        reset_in = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(1, c);
        check("b2b_latency1", 64'(c), 64'd33);
        op         = 1'b0;
        a          = 32'd3;
        b          = 32'd5;
        start      = 1'b1;
        hilo_write = 1'b1;
        tick();
        start      = 1'b0;
        hilo_write = 1'b0;
        check("b2b_hi1", 64'(hi), 64'hFFFF_FFFF);
        check("b2b_lo1", 64'(lo), 64'hFFFF_FFEB);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(1, c);
        check("b2b_latency2", 64'(c), 64'd33);
        hilo_write = 1'b1;
        tick();
        hilo_write = 1'b0;
        check("b2b_hi2", 64'(hi), 64'd0);
        check("b2b_lo2", 64'(lo), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
